dma_streamer: RTL
=================

// Module: dma_streamer
// PURPOSE
//  Per-direction burst generator sitting directly downstream of dma_fsm. It accepts the
//  {valid, idx} descriptor selection on dma_stream_i and splits that descriptor's byte
//  count into AXI-legal burst requests: INCR, at most MAX_BEATS beats, never crossing 4 KB.
//  It returns a one-cycle done on dma_stream_o; dma_fsm uses it to mark the descriptor finished.
//  Two instances are used: STREAM_TYPE=0 feeds the AXI read channel, STREAM_TYPE=1 the write.
// PARAMETERS
//  STREAM_TYPE  0       0: use desc.src_addr (read), 1: use desc.dst_addr (write)
//  ADDR_W       32      address width
//  BYTES_W      32      width of desc.num_bytes and the remaining-bytes counter
//  DATA_W       32      AXI data width in bits; BPB = DATA_W/8 bytes per beat
//  MAX_BEATS    16      max beats per burst (1..256)
// PORTS
//  clk           in   1                      clock
//  rst           in   1                      reset, synchronous, active-high
//  dma_desc_i    in   `DMA_NUM_DESC x desc    CSR descriptors (s_dma_desc_t)
//  dma_stream_i  in   s_dma_str_in_t         {valid, idx} from dma_fsm
//  dma_stream_o  out  s_dma_str_out_t        {done} to dma_fsm
//  clear_i       in   1                      dma_fsm_clear_o; return to IDLE
//  req_valid_o   out  1                      burst request valid
//  req_ready_i   in   1                      AXI I/F accepts request
//  req_addr_o    out  ADDR_W                 burst start address
//  req_len_o     out  8                      AxLEN = beats-1
//  req_size_o    out  3                      AxSIZE = log2(BPB), constant
// BEHAVIOUR
//  Reset: state IDLE; req_valid_o=0, req_addr_o=0, req_len_o=0, done=0, counters 0.
//  States: IDLE -> BURST -> DONE -> IDLE. All outputs are registered or decoded from state.
//  IDLE: on dma_stream_i.valid, load addr = STREAM_TYPE ? dst_addr : src_addr of desc[idx].
//    Force addr[log2(BPB)-1:0]=0 and load rem = num_bytes. If num_bytes==0, go to DONE
//    with no request. Otherwise go to BURST.
//  BURST: compute burst bytes bb = min(rem, 4096-addr[11:0], MAX_BEATS*BPB).
//    beats = ceil(bb/BPB); req_len_o = beats-1. Assert req_valid_o the cycle after entry.
//    addr, len and valid stay stable until req_ready_i (AXI rule).
//    On handshake: addr += bb, rem -= bb. If rem becomes 0, go to DONE. Otherwise deassert
//    valid for exactly one cycle to recompute, then present the next burst.
//  DONE: dma_stream_o.done = 1 for exactly one cycle, then IDLE. dma_fsm latches done and
//    updates idx in that cycle, so IDLE sees the next descriptor on the following cycle.
//    Done-to-next-load latency is one cycle.
//  Abort: dma_fsm drops dma_stream_i.valid when it aborts.
//    - Valid low in BURST with no request pending: go to IDLE at once, no done.
//    - A request is pending: hold it until its handshake completes, then go to IDLE, no done.
//  clear_i: go to IDLE in any state and zero counters. Takes priority over all else except rst.
//  Width: bb and rem arithmetic is BYTES_W wide. The 4 KB distance is 13 bits (1..4096).
//    Last-burst partial bytes round up to a full beat. Byte strobes are not this block's job.
//  Simultaneous handshake with rem reaching 0 and valid dropping: done still pulses.
//  rst mid-burst: everything returns to reset values next cycle; the request is dropped.
// STRUCTURE
//  dma_pkg: s_dma_str_in_t, s_dma_str_out_t, s_dma_desc_t, dma_strm_st_t
//    {IDLE,BURST,DONE}, DMA_4K_BOUNDARY=4096.
//  One sub-module: dma_burst_calc (combinational bb/len from addr, rem), so burst splitting
//  can be checked on its own. Everything else is in dma_streamer.
// TESTING (DATA_W=32, MAX_BEATS=16, req_ready_i=1 unless noted)
//  1 desc0 src=0x1000, 64 B -> one req addr 0x1000 len 15; done pulses one cycle after handshake.
//  2 src=0x0FF0, 64 B -> req 0x0FF0 len 3, then 0x1000 len 11; a single done.
//  3 src=0x2000, 200 B -> lens 15,15,15,1 at 0x2000/0x2040/0x2080/0x20C0; then done.
//  4 src=0x3000, 10 B -> len 2 (3 beats); ready low 5 cycles -> addr/len/valid stable.
//  5 Abort: drop valid while request stalled -> request held to handshake, IDLE, no done.
//    clear_i in BURST -> IDLE next cycle.
//  6 desc0 then desc1, STREAM_TYPE=1, fsm model -> two done pulses; second burst uses
//    desc1.dst_addr; num_bytes=0 -> done with no request.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types for the DMA streamer slice.
// Descriptor, handshake bundles and streamer FSM states.
package dma_pkg;

  localparam int DMA_NUM_DESC    = 2;
  localparam int DMA_IDX_W       = $clog2(DMA_NUM_DESC);
  localparam int DMA_4K_BOUNDARY = 4096;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic                 valid;
    logic [DMA_IDX_W-1:0] idx;
  } s_dma_str_in_t;

  typedef struct packed {
    logic done;
  } s_dma_str_out_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } dma_strm_st_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: bytes and AxLEN for the next burst
// limited by remaining bytes, the 4 KB page and MAX_BEATS.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int BYTES_W   = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic [11:0]        i_page_off,
  input  logic [BYTES_W-1:0] i_rem,
  output logic [BYTES_W-1:0] o_bb,
  output logic [7:0]         o_len
);

  localparam int BPB = DATA_W / 8;
  localparam int OFF = $clog2(BPB);
  localparam logic [BYTES_W-1:0] MAX_B =
    BYTES_W'(MAX_BEATS * BPB);

  logic [12:0]        w_dist;
  logic [BYTES_W-1:0] w_dist_ext;
  logic [BYTES_W-1:0] w_min1;
  logic [BYTES_W-1:0] w_beats;

  // Distance to the next 4 KB page is 1..4096.
  assign w_dist =
    13'(DMA_4K_BOUNDARY) - {1'b0, i_page_off};
  assign w_dist_ext = BYTES_W'(w_dist);

  assign w_min1 =
    (i_rem < w_dist_ext) ? i_rem : w_dist_ext;
  assign o_bb =
    (w_min1 < MAX_B) ? w_min1 : MAX_B;

  // A partial final beat still costs a full beat.
  assign w_beats =
    (o_bb + BYTES_W'(BPB - 1)) >> OFF;
  assign o_len = 8'(w_beats - BYTES_W'(1));

endmodule

// File: rtl/dma_streamer.sv
// Splits one DMA descriptor into AXI INCR burst requests
// and reports completion back to dma_fsm.
module dma_streamer
  import dma_pkg::*;
#(
  parameter int STREAM_TYPE = 0,
  parameter int ADDR_W      = 32,
  parameter int BYTES_W     = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BEATS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  s_dma_desc_t       dma_desc_i [DMA_NUM_DESC],
  input  s_dma_str_in_t     dma_stream_i,
  output s_dma_str_out_t    dma_stream_o,
  input  logic              clear_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [7:0]        req_len_o,
  output logic [2:0]        req_size_o
);

  localparam int BPB = DATA_W / 8;
  localparam int OFF = $clog2(BPB);

  dma_strm_st_t       r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [BYTES_W-1:0] r_rem;
  logic [BYTES_W-1:0] r_bb;
  logic [7:0]         r_len;
  logic               r_valid;

  s_dma_desc_t        w_desc;
  logic [ADDR_W-1:0]  w_ld_addr;
  logic [BYTES_W-1:0] w_bb;
  logic [7:0]         w_len;
  logic               w_hs;
  logic               w_last;

  assign w_desc = dma_desc_i[dma_stream_i.idx];

  assign w_ld_addr =
    ADDR_W'((STREAM_TYPE != 0) ? w_desc.dst_addr
                               : w_desc.src_addr)
    & ~ADDR_W'(BPB - 1);

  assign w_hs   = r_valid & req_ready_i;
  assign w_last = (r_rem == r_bb);

  dma_burst_calc #(
    .BYTES_W   (BYTES_W),
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_calc (
    .i_page_off (r_addr[11:0]),
    .i_rem      (r_rem),
    .o_bb       (w_bb),
    .o_len      (w_len)
  );

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_bb    <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (dma_stream_i.valid) begin
            r_addr  <= w_ld_addr;
            r_rem   <= BYTES_W'(w_desc.num_bytes);
            r_state <= (w_desc.num_bytes == '0)
                       ? DONE : BURST;
          end
        end
        BURST: begin
          if (r_valid) begin
            // Request is frozen until accepted, abort or not.
            if (w_hs) begin
              r_valid <= 1'b0;
              r_addr  <= r_addr + ADDR_W'(r_bb);
              r_rem   <= r_rem - r_bb;
              if (w_last)
                r_state <= DONE;
              else if (!dma_stream_i.valid)
                r_state <= IDLE;
            end
          end else if (!dma_stream_i.valid) begin
            r_state <= IDLE;
          end else begin
            r_valid <= 1'b1;
            r_bb    <= w_bb;
            r_len   <= w_len;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_valid_o       = r_valid;
  assign req_addr_o        = r_addr;
  assign req_len_o         = r_len;
  assign req_size_o        = 3'(OFF);
  assign dma_stream_o.done = (r_state == DONE);

endmodule
